// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared widths, load sizes and loader FSM encoding
package ram_loader_pkg;
   localparam int SIZE_1           = 8;
   localparam int SIZE_9           = 72;
   localparam int SIZE_address_pix = 13;
   localparam int SIZE_address_wei = 9;
   localparam int PIX_COUNT        = 784;
   localparam int WEI_COUNT        = 257;
   localparam logic [SIZE_address_pix-1:0] PIX_LAST = SIZE_address_pix'(PIX_COUNT - 1);
   localparam logic [SIZE_address_wei-1:0] WEI_LAST = SIZE_address_wei'(WEI_COUNT - 1);
   typedef enum logic [1:0] {IDLE, LOAD_PIX, LOAD_WEI, DONE} state_t;
endpackage

// File: rtl/ram_loader_if.sv
// ram_loader_if: byte-serial valid/ready stream feeding the loader
interface ram_loader_if;
   import ram_loader_pkg::*;
   logic [SIZE_1-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   modport master (output in_data, in_valid, input in_ready);
   modport slave  (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/ram_loader_weight_packer.sv
// ram_loader_weight_packer: gathers nine weight elements into one kernel word
module ram_loader_weight_packer
   import ram_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              accept,
   input  logic [SIZE_1-1:0] din,
   output logic              word_valid,
   output logic [SIZE_9-1:0] word
);
   logic [3:0]               k_cnt;
   logic [SIZE_9-SIZE_1-1:0] pack;
   assign word_valid = accept && k_cnt == 4'd8;
   assign word       = {din, pack};
   // shift each element in from the top so the first of nine ends up in the LSBs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_cnt <= '0;
         pack  <= '0;
      end else if (clr) begin
         k_cnt <= '0;
         pack  <= '0;
      end else if (accept) begin
         pack  <= {din, pack[SIZE_9-SIZE_1-1:SIZE_1]};
         k_cnt <= word_valid ? 4'd0 : k_cnt + 4'd1;
      end
   end
endmodule

// File: rtl/ram_loader.sv
// ram_loader: streams one image and its kernel weights into picture/weight RAM
module ram_loader
   import ram_loader_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   ram_loader_if.slave                 stream,
   output logic [SIZE_1-1:0]           dp,
   output logic [SIZE_address_pix-1:0] write_addressp,
   output logic                        we_p,
   output logic [SIZE_9-1:0]           dw,
   output logic [SIZE_address_wei-1:0] write_addressw,
   output logic                        we_w,
   output logic                        busy,
   output logic                        done
);
   state_t                      state;
   logic [SIZE_address_pix-1:0] pix_cnt;
   logic [SIZE_address_wei-1:0] wei_cnt;
   logic                        accept;
   logic                        word_valid;
   logic [SIZE_9-1:0]           word;

   assign accept = stream.in_valid && stream.in_ready;

   ram_loader_weight_packer packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (state == IDLE && start),
      .accept     (accept && state == LOAD_WEI),
      .din        (stream.in_data),
      .word_valid (word_valid),
      .word       (word)
   );

   // load sequencer: every output is registered; enables drop unless an element was just taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         stream.in_ready <= 1'b0;
         pix_cnt         <= '0;
         wei_cnt         <= '0;
         dp              <= '0;
         write_addressp  <= '0;
         we_p            <= 1'b0;
         dw              <= '0;
         write_addressw  <= '0;
         we_w            <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         we_p <= 1'b0;
         we_w <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state           <= LOAD_PIX;
               stream.in_ready <= 1'b1;
               busy            <= 1'b1;
               pix_cnt         <= '0;
               wei_cnt         <= '0;
            end
            LOAD_PIX: if (accept) begin
               we_p           <= 1'b1;
               dp             <= stream.in_data;
               write_addressp <= pix_cnt;
               pix_cnt        <= pix_cnt + 1'b1;
               if (pix_cnt == PIX_LAST) state <= LOAD_WEI;
            end
            LOAD_WEI: if (word_valid) begin
               we_w           <= 1'b1;
               dw             <= word;
               write_addressw <= wei_cnt;
               wei_cnt        <= wei_cnt + 1'b1;
               if (wei_cnt == WEI_LAST) begin
                  state           <= DONE;
                  stream.in_ready <= 1'b0;
                  done            <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed scenarios for the image/weight loader
module tb_ram_loader;
   import ram_loader_pkg::*;
   localparam int TOTAL  = PIX_COUNT + 9 * WEI_COUNT;
   localparam int BUDGET = 20000;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [SIZE_1-1:0]           dp;
   logic [SIZE_address_pix-1:0] write_addressp;
   logic                        we_p;
   logic [SIZE_9-1:0]           dw;
   logic [SIZE_address_wei-1:0] write_addressw;
   logic                        we_w, busy, done;
   int checks = 0, errors = 0;

   ram_loader_if bus ();

   ram_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stream(bus),
      .dp(dp), .write_addressp(write_addressp), .we_p(we_p),
      .dw(dw), .write_addressw(write_addressw), .we_w(we_w),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   logic [SIZE_1-1:0] pix_mem [PIX_COUNT];
   logic [SIZE_9-1:0] wei_mem [WEI_COUNT];
   bit pix_seen [PIX_COUNT];
   bit wei_seen [WEI_COUNT];
   int pix_writes, wei_writes, dup, bad_addr, done_cnt, done_bad, spur, acc_cnt;
   int cyc_n, cyc_first_acc, cyc_last_pix_acc, cyc_first_wei_acc, cyc_pix783_we, cyc_done;
   int first_pix_addr;
   bit prev_acc = 1'b0;

   always @(negedge clk) begin
      int pa, wa;
      pa = int'(write_addressp);
      wa = int'(write_addressw);
      cyc_n++;
      if ((we_p || we_w) && !prev_acc) spur++;
      if (we_p) begin
         if (pa < PIX_COUNT) begin
            if (pix_seen[pa]) dup++;
            pix_seen[pa] = 1'b1;
            pix_mem[pa]  = dp;
         end else bad_addr++;
         if (pix_writes == 0) first_pix_addr = pa;
         if (pa == PIX_COUNT - 1) cyc_pix783_we = cyc_n;
         pix_writes++;
      end
      if (we_w) begin
         if (wa < WEI_COUNT) begin
            if (wei_seen[wa]) dup++;
            wei_seen[wa] = 1'b1;
            wei_mem[wa]  = dw;
         end else bad_addr++;
         wei_writes++;
      end
      if (done) begin
         done_cnt++;
         cyc_done = cyc_n;
         if (!(we_w && wa == WEI_COUNT - 1)) done_bad++;
      end else if (we_w && wa == WEI_COUNT - 1) done_bad++;
      prev_acc = bus.in_valid && bus.in_ready;
      if (prev_acc) begin
         acc_cnt++;
         if (acc_cnt == 1) cyc_first_acc = cyc_n;
         if (acc_cnt == PIX_COUNT) cyc_last_pix_acc = cyc_n;
         if (acc_cnt == PIX_COUNT + 1) cyc_first_wei_acc = cyc_n;
      end
   end

   function automatic logic [SIZE_1-1:0] elem(input int idx);
      return idx < PIX_COUNT ? SIZE_1'(idx % 256) : SIZE_1'((idx - PIX_COUNT) % 128);
   endfunction

   function automatic logic [SIZE_9-1:0] exp_word(input int w);
      logic [SIZE_9-1:0] r;
      for (int k = 0; k < 9; k++) r[k*SIZE_1 +: SIZE_1] = SIZE_1'((9 * w + k) % 128);
      return r;
   endfunction

   function automatic int pix_bad();
      int b = 0;
      for (int i = 0; i < PIX_COUNT; i++) if (pix_mem[i] !== SIZE_1'(i % 256)) b++;
      return b;
   endfunction

   function automatic int wei_bad();
      int b = 0;
      for (int w = 0; w < WEI_COUNT; w++) if (wei_mem[w] !== exp_word(w)) b++;
      return b;
   endfunction

   task automatic clear_mon();
      foreach (pix_mem[i]) begin pix_mem[i] = 'x; pix_seen[i] = 1'b0; end
      foreach (wei_mem[i]) begin wei_mem[i] = 'x; wei_seen[i] = 1'b0; end
      pix_writes = 0; wei_writes = 0; dup = 0; bad_addr = 0; done_cnt = 0; done_bad = 0;
      spur = 0; acc_cnt = 0; cyc_first_acc = -1; cyc_last_pix_acc = -1;
      cyc_first_wei_acc = -1; cyc_pix783_we = -1; cyc_done = -1; first_pix_addr = -1;
   endtask

   task automatic run_load(input bit stall, input int start_at, input int abort_word, output bit timeout);
      int idx, cyc;
      bit acc, pulsed;
      idx = 0; cyc = 0; pulsed = 0; timeout = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      while (idx < TOTAL) begin
         if (cyc >= BUDGET) begin timeout = 1'b1; break; end
         bus.in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.in_data  = elem(idx);
         if (idx == start_at && !pulsed) begin start = 1'b1; pulsed = 1'b1; end
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         #1;
         if (abort_word >= 0 && wei_writes > abort_word) break;
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
         if (acc) idx++;
      end
      bus.in_valid = 1'b0;
      if (abort_word < 0) begin
         for (int k = 0; k < 20 && busy; k++) @(negedge clk);
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b1; bus.in_data = 8'h5a;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.in_ready, we_p, we_w, busy, done} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b, want 00000", {bus.in_ready, we_p, we_w, busy, done});
      end
      checks++;
      if ({dp, write_addressp, dw, write_addressw} !== '0) begin
         errors++; $display("FAIL reset_data: got dp=%h ap=%h dw=%h aw=%h, want all 0", dp, write_addressp, dw, write_addressw);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if ({bus.in_ready, we_p, we_w, busy, done} !== 5'b0) begin
            errors++; $display("FAIL idle_cycle%0d: got rdy/wep/wew/busy/done=%b, want 00000", c, {bus.in_ready, we_p, we_w, busy, done});
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_stream();
      bit to;
      clear_mon();
      run_load(1'b0, -1, -1, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL stream_timeout: stream did not complete in %0d cycles", BUDGET); end
      checks++; if (pix_writes != PIX_COUNT) begin errors++; $display("FAIL stream_pix_writes: got %0d, want %0d", pix_writes, PIX_COUNT); end
      checks++; if (pix_bad() != 0) begin errors++; $display("FAIL stream_pix_image: %0d bad pixels, want 0", pix_bad()); end
      checks++; if (wei_mem[0] !== 72'h08_07_06_05_04_03_02_01_00) begin errors++; $display("FAIL stream_word0: got %h, want 080706050403020100", wei_mem[0]); end
      checks++; if (wei_writes != WEI_COUNT) begin errors++; $display("FAIL stream_wei_writes: got %0d, want %0d", wei_writes, WEI_COUNT); end
      checks++; if (wei_bad() != 0) begin errors++; $display("FAIL stream_wei_image: %0d bad words, want 0", wei_bad()); end
      checks++; if (dup != 0 || bad_addr != 0) begin errors++; $display("FAIL stream_addr: dup=%0d out_of_range=%0d, want 0/0", dup, bad_addr); end
      checks++; if (done_cnt != 1 || done_bad != 0) begin errors++; $display("FAIL stream_done: pulses=%0d misplaced=%0d, want 1/0", done_cnt, done_bad); end
      checks++; if (cyc_done - cyc_first_acc != TOTAL) begin errors++; $display("FAIL stream_no_bubbles: first accept to done %0d cycles, want %0d", cyc_done - cyc_first_acc, TOTAL); end
      checks++; if (spur != 0) begin errors++; $display("FAIL stream_spurious_we: got %0d, want 0", spur); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy_end: got %b, want 0", busy); end
   endtask

   task automatic test_boundary();
      bit to;
      clear_mon();
      run_load(1'b0, -1, -1, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL boundary_timeout: load did not complete"); end
      checks++; if (cyc_first_wei_acc != cyc_last_pix_acc + 1) begin errors++; $display("FAIL boundary_accept: first weight at cycle %0d, want %0d", cyc_first_wei_acc, cyc_last_pix_acc + 1); end
      checks++; if (cyc_pix783_we != cyc_last_pix_acc + 1) begin errors++; $display("FAIL boundary_we783: write at cycle %0d, want %0d", cyc_pix783_we, cyc_last_pix_acc + 1); end
      checks++; if (pix_mem[PIX_COUNT-1] !== 8'd15) begin errors++; $display("FAIL boundary_pix783: got %h, want 0f", pix_mem[PIX_COUNT-1]); end
      checks++; if (wei_mem[0][7:0] !== 8'd0 || wei_mem[1] !== exp_word(1)) begin errors++; $display("FAIL boundary_slot0: word0 %h word1 %h, want slot0 00 and %h", wei_mem[0], wei_mem[1], exp_word(1)); end
      checks++; if (pix_writes + wei_writes != PIX_COUNT + WEI_COUNT) begin errors++; $display("FAIL boundary_write_total: got %0d, want %0d", pix_writes + wei_writes, PIX_COUNT + WEI_COUNT); end
   endtask

   task automatic test_random_stalls();
      bit to;
      clear_mon();
      run_load(1'b1, -1, -1, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL stall_timeout: load did not complete"); end
      checks++; if (pix_writes != PIX_COUNT || wei_writes != WEI_COUNT) begin errors++; $display("FAIL stall_writes: got %0d/%0d, want %0d/%0d", pix_writes, wei_writes, PIX_COUNT, WEI_COUNT); end
      checks++; if (pix_bad() != 0) begin errors++; $display("FAIL stall_pix_image: %0d bad pixels, want 0", pix_bad()); end
      checks++; if (wei_bad() != 0) begin errors++; $display("FAIL stall_wei_image: %0d bad words, want 0", wei_bad()); end
      checks++; if (spur != 0) begin errors++; $display("FAIL stall_spurious_we: got %0d, want 0", spur); end
      checks++; if (done_cnt != 1 || done_bad != 0 || dup != 0) begin errors++; $display("FAIL stall_done_dup: done=%0d misplaced=%0d dup=%0d, want 1/0/0", done_cnt, done_bad, dup); end
   endtask

   task automatic test_start_while_busy();
      bit to;
      clear_mon();
      run_load(1'b0, 100, -1, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL busy_start_timeout: load did not complete"); end
      checks++; if (pix_writes != PIX_COUNT || dup != 0) begin errors++; $display("FAIL busy_start_pix: writes=%0d dup=%0d, want %0d/0", pix_writes, dup, PIX_COUNT); end
      checks++; if (pix_bad() != 0) begin errors++; $display("FAIL busy_start_image: %0d bad pixels, want 0", pix_bad()); end
      checks++; if (wei_writes != WEI_COUNT || wei_bad() != 0) begin errors++; $display("FAIL busy_start_wei: writes=%0d bad=%0d, want %0d/0", wei_writes, wei_bad(), WEI_COUNT); end
      checks++; if (cyc_done - cyc_first_acc != TOTAL) begin errors++; $display("FAIL busy_start_length: %0d cycles, want %0d", cyc_done - cyc_first_acc, TOTAL); end
   endtask

   task automatic test_reset_mid_load();
      bit to;
      int pw, ww;
      clear_mon();
      run_load(1'b0, -1, 10, to);
      checks++; if (wei_writes != 11) begin errors++; $display("FAIL midrst_progress: wei_writes=%0d, want 11", wei_writes); end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.in_ready, we_p, we_w, busy, done} !== 5'b0) begin
         errors++; $display("FAIL midrst_ctrl: got %b, want 00000", {bus.in_ready, we_p, we_w, busy, done});
      end
      checks++;
      if ({dp, write_addressp, dw, write_addressw} !== '0) begin
         errors++; $display("FAIL midrst_data: got dp=%h ap=%h dw=%h aw=%h, want all 0", dp, write_addressp, dw, write_addressw);
      end
      pw = pix_writes; ww = wei_writes;
      bus.in_valid = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      bus.in_valid = 1'b0;
      checks++; if (pix_writes != pw || wei_writes != ww || busy !== 1'b0) begin errors++; $display("FAIL midrst_quiet: writes %0d/%0d busy %b, want %0d/%0d busy 0", pix_writes, wei_writes, busy, pw, ww); end
      clear_mon();
      run_load(1'b0, -1, -1, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL midrst_reload_timeout: load did not complete"); end
      checks++; if (first_pix_addr != 0) begin errors++; $display("FAIL midrst_first_addr: got %0d, want 0", first_pix_addr); end
      checks++; if (pix_writes != PIX_COUNT || pix_bad() != 0) begin errors++; $display("FAIL midrst_pix: writes=%0d bad=%0d, want %0d/0", pix_writes, pix_bad(), PIX_COUNT); end
      checks++; if (wei_writes != WEI_COUNT || wei_bad() != 0) begin errors++; $display("FAIL midrst_wei: writes=%0d bad=%0d, want %0d/0", wei_writes, wei_bad(), WEI_COUNT); end
      checks++; if (done_cnt != 1 || done_bad != 0) begin errors++; $display("FAIL midrst_done: pulses=%0d misplaced=%0d, want 1/0", done_cnt, done_bad); end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      clear_mon();
      test_reset();
      test_stream();
      test_boundary();
      test_random_stalls();
      test_start_while_busy();
      test_reset_mid_load();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Upstream feeder for the RAM block. It accepts a byte-serial stream of one digit image followed by the convolution weights over a valid/ready handshake.
- Pixels go to the picture memory as one SIZE_1 word per address.
- Weights are packed nine per word (one 3x3 kernel) and written to the weight memory.
- Sequences one complete load per start pulse, then signals done to the network controller.

Parameters:
- SIZE_1, 8, width of one pixel or weight element
- SIZE_9, 72, packed kernel word width; must equal 9*SIZE_1
- SIZE_address_pix, 13, picture memory address width
- SIZE_address_wei, 9, weight memory address width
- PIX_COUNT, 784, pixels per image (28x28)
- WEI_COUNT, 257, packed kernel words per load (addresses 0..256)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begins a load when idle
- in_data  in  SIZE_1  signed stream element
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  loader accepts in_data this cycle
- dp  out  SIZE_1  picture write data, to RAM dp
- write_addressp  out  SIZE_address_pix  picture write address
- we_p  out  1  picture write enable
- dw  out  SIZE_9  packed weight write data, to RAM dw
- write_addressw  out  SIZE_address_wei  weight write address
- we_w  out  1  weight write enable
- busy  out  1  high while loading
- done  out  1  one-cycle pulse when the last weight word is written

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state IDLE
  - all outputs 0, including in_ready, we_p, we_w, busy and done
  - counters and packing register cleared
- Reset mid-load: the load is abandoned and no further writes are issued. Memory contents already written are left untouched. A new start is required.
- Handshake: an element is accepted in a cycle only when in_valid=1 and in_ready=1. in_data is ignored otherwise.
- in_ready is a registered output: 1 in LOAD_PIX and LOAD_WEI, 0 in IDLE and DONE.
- FSM IDLE:
  - busy=0
  - start=1 moves to LOAD_PIX and clears pix_cnt, k_cnt and wei_cnt
- FSM LOAD_PIX:
  - Each accepted element at cycle N produces, in cycle N+1: we_p=1, dp=in_data, write_addressp=pix_cnt. pix_cnt then increments.
  - Acceptance of the element with pix_cnt=PIX_COUNT-1 moves to LOAD_WEI.
  - we_p=0 in any cycle following a non-accepting cycle.
- FSM LOAD_WEI:
  - Accepted element with group index k_cnt (0..8) is placed at packing bits [(k_cnt+1)*SIZE_1-1 : k_cnt*SIZE_1]. The first element lands in the LSBs.
  - On acceptance with k_cnt=8, the next cycle drives we_w=1, dw=the complete packed word including this element, write_addressw=wei_cnt. k_cnt returns to 0 and wei_cnt increments.
  - Acceptance completing word wei_cnt=WEI_COUNT-1 moves to DONE.
- FSM DONE:
  - done=1 for exactly the cycle the final we_w is asserted
  - returns to IDLE on the next cycle
- busy=1 from the cycle after start through the DONE cycle inclusive.
- start while busy=1 is ignored. It does not restart or alter the counters.
- Back-to-back: in_valid held high yields one write per cycle with no bubbles. This includes the LOAD_PIX to LOAD_WEI transition, where the first weight element is accepted in the cycle after the last pixel.
- Stalls: in_valid=0 holds all counters and the packing register. Only we_p or we_w drops.
- Write address outputs and data hold their last value when the enable is low.
- Total load: exactly PIX_COUNT picture writes at addresses 0..PIX_COUNT-1, then exactly WEI_COUNT weight writes at addresses 0..WEI_COUNT-1. No address is written twice per load.
- Counters are wide enough that pix_cnt and wei_cnt never wrap within a load.

Decomposition:
- Shared package (neuroset defines):
  - SIZE_1, SIZE_9, the address widths, PIX_COUNT, WEI_COUNT
  - FSM state encoding IDLE/LOAD_PIX/LOAD_WEI/DONE
- One natural sub-module: weight_packer. It holds k_cnt and the SIZE_9 shift/insert register, and outputs word_valid with the packed word.
- The FSM, pixel path and address counters stay in ram_loader.

Test Plan:
- Reset then idle: hold start=0 for 10 cycles with in_valid=1 -> in_ready=0, we_p=0, we_w=0, busy=0.
- Full streaming load: start, then 784 pixels of value i mod 256, then 257*9 weights of value j mod 128, with in_valid always 1. Expected:
  - 784 we_p pulses, address i carrying data i mod 256
  - word 0 dw = elements 0..8 packed LSB-first
  - exactly 257 we_w pulses at addresses 0..256
  - done is a single pulse coincident with the write to address 256
- Random stalls: same data with in_valid toggling pseudo-randomly at 50% -> identical memory image to the streaming run, and we_p/we_w never high after a non-accepting cycle.
- Boundary: the last pixel (address 783) and the first weight element are accepted in consecutive cycles -> we_p at 783, then the next element goes to packing slot 0 with no extra write.
- Start while busy: pulse start at pixel 100 -> pix_cnt unaffected, writes continue at 101.
- Reset mid-load: assert rst_n=0 after weight word 10 -> outputs 0 immediately. A new start gives a fresh load beginning at pixel address 0.
